// File: rtl/uart_debug_ctrl_if.sv
// Bundle of the debug controller's UART, instruction-memory and CPU-control signals.
// The controller uses the master modport; the surrounding environment uses slave.
interface uart_debug_ctrl_if #(
    parameter int IMEM_AW = 8
);
    logic               i_rx_done;
    logic [7:0]         i_rx_data;
    logic               i_tx_done;
    logic               i_cpu_halt;
    logic [31:0]        i_pc;
    logic               o_tx_start;
    logic [7:0]         o_tx_data;
    logic               o_imem_we;
    logic [IMEM_AW-1:0] o_imem_addr;
    logic [31:0]        o_imem_data;
    logic               o_cpu_en;
    logic               o_load_done;
    logic               o_cmd_err;
    logic               o_busy;

    modport master (
        input  i_rx_done, i_rx_data, i_tx_done, i_cpu_halt, i_pc,
        output o_tx_start, o_tx_data, o_imem_we, o_imem_addr, o_imem_data,
        output o_cpu_en, o_load_done, o_cmd_err, o_busy
    );

    modport slave (
        output i_rx_done, i_rx_data, i_tx_done, i_cpu_halt, i_pc,
        input  o_tx_start, o_tx_data, o_imem_we, o_imem_addr, o_imem_data,
        input  o_cpu_en, o_load_done, o_cmd_err, o_busy
    );
endinterface

// File: rtl/uart_debug_ctrl.sv
// UART debug controller: loads instruction memory from a byte stream, runs or
// single-steps the CPU, then reports the PC back over the transmitter, LSB first.
module uart_debug_ctrl #(
    parameter int IMEM_AW = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    uart_debug_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP, TX_LOAD, TX_WAIT
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;

    state_t             r_state, w_state_nxt;
    logic               r_rx_prev;
    logic               r_rx_armed;
    logic [7:0]         r_count, w_count_nxt;
    logic [1:0]         r_idx, w_idx_nxt;
    logic [IMEM_AW-1:0] r_addr, w_addr_nxt;
    logic [31:0]        r_word, w_word_nxt;
    logic [31:0]        r_pc_shadow, w_pc_shadow_nxt;
    logic [1:0]         r_k, w_k_nxt;
    logic [7:0]         r_tx_data, w_tx_data_nxt;
    logic               r_tx_start, w_tx_start_nxt;
    logic               r_load_done, w_load_done_nxt;
    logic               r_cmd_err, w_cmd_err_nxt;
    logic               w_rx_accept;

    // Armed only after rx_done has been seen low, so a flag still high across reset is not a new byte.
    assign w_rx_accept = bus.i_rx_done & ~r_rx_prev & r_rx_armed;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_rx_prev   <= 1'b0;
            r_rx_armed  <= 1'b0;
            r_count     <= '0;
            r_idx       <= '0;
            r_addr      <= '0;
            r_word      <= '0;
            r_pc_shadow <= '0;
            r_k         <= '0;
            r_tx_data   <= '0;
            r_tx_start  <= 1'b0;
            r_load_done <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rx_prev   <= bus.i_rx_done;
            r_rx_armed  <= r_rx_armed | ~bus.i_rx_done;
            r_count     <= w_count_nxt;
            r_idx       <= w_idx_nxt;
            r_addr      <= w_addr_nxt;
            r_word      <= w_word_nxt;
            r_pc_shadow <= w_pc_shadow_nxt;
            r_k         <= w_k_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_start  <= w_tx_start_nxt;
            r_load_done <= w_load_done_nxt;
            r_cmd_err   <= w_cmd_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_idx_nxt       = r_idx;
        w_addr_nxt      = r_addr;
        w_word_nxt      = r_word;
        w_pc_shadow_nxt = r_pc_shadow;
        w_k_nxt         = r_k;
        w_tx_data_nxt   = r_tx_data;
        w_tx_start_nxt  = 1'b0;
        w_load_done_nxt = 1'b0;
        w_cmd_err_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_rx_accept) begin
                    w_k_nxt = '0;
                    case (bus.i_rx_data)
                        CMD_LOAD: w_state_nxt   = LD_CNT;
                        CMD_RUN:  w_state_nxt   = RUN;
                        CMD_STEP: w_state_nxt   = STEP;
                        default:  w_cmd_err_nxt = 1'b1;
                    endcase
                end
            end
            LD_CNT: begin
                if (w_rx_accept) begin
                    if (bus.i_rx_data == 8'd0) begin
                        w_load_done_nxt = 1'b1;
                        w_state_nxt     = IDLE;
                    end else begin
                        w_count_nxt = bus.i_rx_data;
                        w_addr_nxt  = '0;
                        w_idx_nxt   = '0;
                        w_state_nxt = LD_BYTE;
                    end
                end
            end
            LD_BYTE: begin
                if (w_rx_accept) begin
                    w_word_nxt[{r_idx, 3'b000} +: 8] = bus.i_rx_data;
                    w_idx_nxt = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_state_nxt = LD_WR;
                    end
                end
            end
            LD_WR: begin
                // The write strobe is decoded from this state; step the pointer for the next word.
                w_addr_nxt  = r_addr + IMEM_AW'(1);
                w_count_nxt = r_count - 8'd1;
                if (r_count == 8'd1) begin
                    w_load_done_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end else begin
                    w_state_nxt = LD_BYTE;
                end
            end
            RUN: begin
                if (bus.i_cpu_halt) begin
                    w_state_nxt = TX_LOAD;
                end
            end
            STEP: begin
                w_state_nxt = TX_LOAD;
            end
            TX_LOAD: begin
                if (r_k == 2'd0) begin
                    w_pc_shadow_nxt = bus.i_pc;
                    w_tx_data_nxt   = bus.i_pc[7:0];
                end else begin
                    w_tx_data_nxt = r_pc_shadow[{r_k, 3'b000} +: 8];
                end
                w_tx_start_nxt = 1'b1;
                w_state_nxt    = TX_WAIT;
            end
            TX_WAIT: begin
                if (bus.i_tx_done) begin
                    w_k_nxt     = r_k + 2'd1;
                    w_state_nxt = (r_k == 2'd3) ? IDLE : TX_LOAD;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.o_tx_start  = r_tx_start;
    assign bus.o_tx_data   = r_tx_data;
    assign bus.o_imem_we   = (r_state == LD_WR);
    assign bus.o_imem_addr = r_addr;
    assign bus.o_imem_data = r_word;
    assign bus.o_cpu_en    = (r_state == RUN) || (r_state == STEP);
    assign bus.o_load_done = r_load_done;
    assign bus.o_cmd_err   = r_cmd_err;
    assign bus.o_busy      = (r_state != IDLE);
endmodule

// File: tb/tb_uart_debug_ctrl.sv
// Bench for uart_debug_ctrl: decode table, directed load/step/run/reset sequences and
// randomized command traffic checked against a transaction-level model.
module tb_uart_debug_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx_done, tx_done, cpu_halt;
    logic [7:0]  rx_data;
    logic [31:0] pc;

    uart_debug_ctrl_if #(.IMEM_AW(8)) bus8 ();
    uart_debug_ctrl_if #(.IMEM_AW(2)) bus2 ();

    assign bus8.i_rx_done  = rx_done;
    assign bus8.i_rx_data  = rx_data;
    assign bus8.i_tx_done  = tx_done;
    assign bus8.i_cpu_halt = cpu_halt;
    assign bus8.i_pc       = pc;
    assign bus2.i_rx_done  = rx_done;
    assign bus2.i_rx_data  = rx_data;
    assign bus2.i_tx_done  = tx_done;
    assign bus2.i_cpu_halt = cpu_halt;
    assign bus2.i_pc       = pc;

    uart_debug_ctrl #(.IMEM_AW(8)) dut8 (.i_clk(clk), .i_reset(rst), .bus(bus8));
    uart_debug_ctrl #(.IMEM_AW(2)) dut2 (.i_clk(clk), .i_reset(rst), .bus(bus2));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_we = 0, cnt_ld = 0, cnt_err = 0, cnt_start = 0, cnt_cpu = 0;

    typedef struct {
        logic [7:0]  a8;
        logic [1:0]  a2;
        logic [31:0] d;
    } wr_t;
    wr_t        q_wr[$];
    logic [7:0] q_tx[$];
    logic [31:0] ld_words[$];
    logic p_we = 1'b0, p_st = 1'b0, p_ld = 1'b0, p_er = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Observation of pulses, writes and transmit requests on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            p_we = 1'b0; p_st = 1'b0; p_ld = 1'b0; p_er = 1'b0;
        end else begin
            if (bus8.o_imem_we) begin
                check("we_back_to_back", {31'd0, p_we}, 32'd0);
                q_wr.push_back('{bus8.o_imem_addr, bus2.o_imem_addr, bus8.o_imem_data});
                cnt_we++;
            end
            if (bus8.o_tx_start) begin
                check("tx_start_back_to_back", {31'd0, p_st}, 32'd0);
                q_tx.push_back(bus8.o_tx_data);
                cnt_start++;
            end
            if (bus8.o_load_done) begin
                check("load_done_back_to_back", {31'd0, p_ld}, 32'd0);
                cnt_ld++;
            end
            if (bus8.o_cmd_err) begin
                check("cmd_err_back_to_back", {31'd0, p_er}, 32'd0);
                cnt_err++;
            end
            if (bus8.o_cpu_en) cnt_cpu++;
            p_we = bus8.o_imem_we;
            p_st = bus8.o_tx_start;
            p_ld = bus8.o_load_done;
            p_er = bus8.o_cmd_err;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            if (!bus8.o_busy) break;
            @(negedge clk);
        end
        check(name, {31'd0, bus8.o_busy}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_tx_data"}, {24'd0, bus8.o_tx_data}, 32'd0);
        check({name, "_imem_addr"}, {24'd0, bus8.o_imem_addr}, 32'd0);
        check({name, "_imem_data"}, bus8.o_imem_data, 32'd0);
        check({name, "_strobes"}, {26'd0, bus8.o_imem_we, bus8.o_tx_start, bus8.o_load_done,
              bus8.o_cmd_err, bus8.o_cpu_en, bus8.o_busy}, 32'd0);
    endtask

    // Answers the four PC report bytes; the expected byte k is simply pcv >> 8k.
    task automatic serve_report(input logic [31:0] pcv, input bit junk);
        int d;
        for (int k = 0; k < 4; k++) begin
            int t;
            t = 0;
            while (q_tx.size() <= k && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (q_tx.size() <= k) begin
                check("tx_start_timeout", 32'd0, 32'd1);
                return;
            end
            if (k == 0) pc = $urandom;
            d = $urandom_range(1, 4);
            for (int i = 0; i < d; i++) begin
                if (junk && i == 0) begin
                    rx_data = 8'($urandom);
                    rx_done = 1'b1;
                end
                @(negedge clk);
            end
            rx_done = 1'b0;
            check("tx_data_held", {24'd0, bus8.o_tx_data}, (pcv >> (8 * k)) & 32'hFF);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
        for (int k = 0; k < 4; k++)
            check("tx_start_byte", {24'd0, q_tx[k]}, (pcv >> (8 * k)) & 32'hFF);
    endtask

    task automatic do_load(input string name);
        int n, w0, l0, e0;
        n = ld_words.size();
        q_wr.delete();
        w0 = cnt_we; l0 = cnt_ld; e0 = cnt_err;
        send_byte(8'h4C);
        send_byte(8'(n));
        foreach (ld_words[i])
            for (int b = 0; b < 4; b++) send_byte(8'(ld_words[i] >> (8 * b)));
        tick(2);
        wait_idle({name, "_idle"});
        check({name, "_we_count"}, cnt_we - w0, n);
        check({name, "_load_done"}, cnt_ld - l0, 1);
        check({name, "_no_err"}, cnt_err - e0, 0);
        for (int i = 0; i < n && i < q_wr.size(); i++) begin
            check({name, "_addr"}, {24'd0, q_wr[i].a8}, i % 256);
            check({name, "_addr_aw2"}, {30'd0, q_wr[i].a2}, i % 4);
            check({name, "_data"}, q_wr[i].d, ld_words[i]);
        end
    endtask

    task automatic do_step(input string name, input logic [31:0] pcv, input bit junk);
        int c0, s0, e0;
        q_tx.delete();
        c0 = cnt_cpu; s0 = cnt_start; e0 = cnt_err;
        pc = pcv;
        send_byte(8'h53);
        serve_report(pcv, junk);
        tick(2);
        wait_idle({name, "_idle"});
        check({name, "_cpu_en_cycles"}, cnt_cpu - c0, 1);
        check({name, "_starts"}, cnt_start - s0, 4);
        check({name, "_no_err"}, cnt_err - e0, 0);
    endtask

    // Halt is raised after w extra cycles of RUN; two RUN cycles have passed when send_byte returns.
    task automatic do_run(input string name, input logic [31:0] pcv, input int w,
                          input bit pre_halt, input bit junk);
        int c0, s0, e0, exp_cpu;
        q_tx.delete();
        c0 = cnt_cpu; s0 = cnt_start; e0 = cnt_err;
        pc = pcv;
        if (pre_halt) begin
            cpu_halt = 1'b1;
            send_byte(8'h52);
            exp_cpu = 1;
        end else begin
            send_byte(8'h52);
            for (int i = 0; i < w; i++) begin
                if (junk && i == 0) begin
                    rx_data = 8'($urandom);
                    rx_done = 1'b1;
                end
                if (i == 1) rx_done = 1'b0;
                @(negedge clk);
            end
            rx_done = 1'b0;
            cpu_halt = 1'b1;
            exp_cpu = 2 + w;
        end
        serve_report(pcv, junk);
        tick(2);
        wait_idle({name, "_idle"});
        cpu_halt = 1'b0;
        check({name, "_cpu_en_cycles"}, cnt_cpu - c0, exp_cpu);
        check({name, "_starts"}, cnt_start - s0, 4);
        check({name, "_no_err"}, cnt_err - e0, 0);
    endtask

    typedef struct {
        logic [7:0] b;
        bit         exp_err;
        bit         exp_busy;
    } dec_vec_t;

    initial begin
        dec_vec_t tab[9];
        int e0, l0, w0, c0, s0;
        logic [7:0] junkb;
        time t0;

        tab[0] = '{8'h00, 1'b1, 1'b0};
        tab[1] = '{8'h7F, 1'b1, 1'b0};
        tab[2] = '{8'hFF, 1'b1, 1'b0};
        tab[3] = '{8'h4B, 1'b1, 1'b0};
        tab[4] = '{8'h4D, 1'b1, 1'b0};
        tab[5] = '{8'h51, 1'b1, 1'b0};
        tab[6] = '{8'h54, 1'b1, 1'b0};
        tab[7] = '{8'h4C, 1'b0, 1'b1};
        tab[8] = '{8'hCC, 1'b1, 1'b0};

        rst = 1'b1; rx_done = 1'b0; tx_done = 1'b0; cpu_halt = 1'b0; rx_data = 8'h00; pc = 32'h0;
        tick(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        tick(2);

        // IDLE command decode
        foreach (tab[i]) begin
            e0 = cnt_err; l0 = cnt_ld;
            send_byte(tab[i].b);
            check("decode_err", cnt_err - e0, {31'd0, tab[i].exp_err});
            check("decode_busy", {31'd0, bus8.o_busy}, {31'd0, tab[i].exp_busy});
            if (tab[i].exp_busy) begin
                send_byte(8'h00);
                check("load_zero_done", cnt_ld - l0, 1);
                check("load_zero_idle", {31'd0, bus8.o_busy}, 32'd0);
            end
        end

        ld_words = '{32'h12345678, 32'hDEADBEEF};
        do_load("load_two");

        s0 = cnt_start;
        @(negedge clk); tx_done = 1'b1; @(negedge clk); tx_done = 1'b0; tick(3);
        check("stray_tx_done_ignored", cnt_start - s0, 0);
        check("stray_tx_done_idle", {31'd0, bus8.o_busy}, 32'd0);

        do_step("step_104", 32'h0000_0104, 1'b0);
        do_run("run_20", 32'hCAFE_F00D, 18, 1'b0, 1'b0);
        do_run("run_prehalt", 32'h8000_0001, 0, 1'b1, 1'b0);

        // Receive flag held high for 50 cycles must give a single step
        q_tx.delete();
        c0 = cnt_cpu; s0 = cnt_start; e0 = cnt_err;
        pc = 32'hA1B2_C3D4;
        @(negedge clk);
        t0 = $time;
        rx_data = 8'h53;
        rx_done = 1'b1;
        serve_report(32'hA1B2_C3D4, 1'b0);
        while ($time - t0 < 500) @(negedge clk);
        rx_done = 1'b0;
        tick(3);
        wait_idle("held_rx_idle");
        check("held_rx_cpu_en", cnt_cpu - c0, 1);
        check("held_rx_starts", cnt_start - s0, 4);
        check("held_rx_no_err", cnt_err - e0, 0);

        ld_words = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005};
        do_load("load_wrap");

        // Reset in the middle of a word
        w0 = cnt_we;
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        tick(2);
        rst = 1'b0;
        e0 = cnt_err;
        send_byte(8'h11);
        send_byte(8'h22);
        tick(3);
        check("midload_reset_no_we", cnt_we - w0, 0);
        check("midload_reset_err", cnt_err - e0, 2);
        check("midload_reset_idle", {31'd0, bus8.o_busy}, 32'd0);
        ld_words = '{32'h0BAD_F00D};
        do_load("load_after_reset");

        // Reset released with the receive flag already high
        @(negedge clk);
        rx_data = 8'h53;
        rx_done = 1'b1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        c0 = cnt_cpu; e0 = cnt_err;
        tick(6);
        check("rx_high_at_release_idle", {31'd0, bus8.o_busy}, 32'd0);
        check("rx_high_at_release_cpu", cnt_cpu - c0, 0);
        check("rx_high_at_release_err", cnt_err - e0, 0);
        rx_done = 1'b0;
        tick(2);
        do_step("step_after_release", 32'h1357_9BDF, 1'b0);

        // Randomized command traffic
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    ld_words.delete();
                    for (int i = $urandom_range(0, 6); i > 0; i--) ld_words.push_back($urandom);
                    do_load("rnd_load");
                end
                1: do_step("rnd_step", $urandom, 1'($urandom_range(0, 1)));
                2: begin
                    if ($urandom_range(0, 3) == 0)
                        do_run("rnd_run", $urandom, 0, 1'b1, 1'b0);
                    else
                        do_run("rnd_run", $urandom, $urandom_range(2, 30), 1'b0,
                               1'($urandom_range(0, 1)));
                end
                default: begin
                    junkb = 8'($urandom);
                    while (junkb == 8'h4C || junkb == 8'h52 || junkb == 8'h53) junkb = 8'($urandom);
                    e0 = cnt_err;
                    send_byte(junkb);
                    check("rnd_err_pulse", cnt_err - e0, 1);
                    check("rnd_err_idle", {31'd0, bus8.o_busy}, 32'd0);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
